// File: rtl/syst_skew.sv
// syst_skew: takes packed words from syst_fifo and skews them so that lane k
// reaches systolic-array row k exactly k+1 cycles after the word is accepted.
// Cycles without a transfer push zero data with valid 0 into every lane
// (array bubbles). After the last word of a block the input stalls for LANES
// cycles while the skew drains, and done_o pulses when the block's final
// byte leaves the last lane.
// Optional feature: define SYST_SKEW_WORD_CNT_EN to add word_cnt_o, a
// saturating count of words accepted in the current block.
// LANES must be at least 2.
module syst_skew #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned LANE_W = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [LANES*LANE_W-1:0] data_i,
    input  logic                    valid_i,
    input  logic                    last_i,
    output logic                    ready_o,
    output logic [LANES*LANE_W-1:0] lane_data_o,
    output logic [LANES-1:0]        lane_valid_o,
    output logic                    done_o
`ifdef SYST_SKEW_WORD_CNT_EN
    ,
    output logic [15:0]             word_cnt_o
`endif
);

    localparam int unsigned DW   = LANES * LANE_W;
    localparam int unsigned CntW = $clog2(LANES) + 1;
    localparam logic [CntW-1:0] DrainLoad = CntW'(LANES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StDrain
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] drain_cnt_q, drain_cnt_d;
    logic            xfer;
    logic [DW-1:0]   in_data;

    assign xfer    = valid_i & ready_o;
    // Non-transfer cycles inject zeros so bubbles reach the array as clean zeros.
    assign in_data = xfer ? data_i : '0;

    // Next-state, drain counter and handshake outputs.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        ready_o     = rst_i & (state_q != StDrain);
        done_o      = (state_q == StDrain) && (drain_cnt_q == '0);
        unique case (state_q)
            StIdle: begin
                if (xfer) begin
                    if (last_i) begin
                        state_d     = StDrain;
                        drain_cnt_d = DrainLoad;
                    end else begin
                        state_d = StStream;
                    end
                end
            end
            StStream: begin
                if (xfer && last_i) begin
                    state_d     = StDrain;
                    drain_cnt_d = DrainLoad;
                end
            end
            StDrain: begin
                if (drain_cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    drain_cnt_d = drain_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d     = StIdle;
                drain_cnt_d = '0;
            end
        endcase
    end

    // FSM state and drain counter registers.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= StIdle;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Lane k owns a k+1 deep delay chain; chains advance every cycle.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [LANE_W-1:0] data_q  [k+1];
        logic              valid_q [k+1];

        // Shift the lane's delay chain; reset flushes any in-flight bytes.
        always_ff @(posedge clk_i) begin
            if (!rst_i) begin
                for (int j = 0; j <= k; j++) begin
                    data_q[j]  <= '0;
                    valid_q[j] <= 1'b0;
                end
            end else begin
                data_q[0]  <= in_data[k*LANE_W +: LANE_W];
                valid_q[0] <= xfer;
                for (int j = 1; j <= k; j++) begin
                    data_q[j]  <= data_q[j-1];
                    valid_q[j] <= valid_q[j-1];
                end
            end
        end

        assign lane_data_o[k*LANE_W +: LANE_W] = data_q[k];
        assign lane_valid_o[k]                 = valid_q[k];
    end

`ifdef SYST_SKEW_WORD_CNT_EN
    logic [15:0] word_cnt_q;

    // Count accepted words; hold through the done cycle, then clear.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            word_cnt_q <= '0;
        end else if (done_o) begin
            word_cnt_q <= '0;
        end else if (xfer && (word_cnt_q != 16'hFFFF)) begin
            word_cnt_q <= word_cnt_q + 16'd1;
        end
    end

    assign word_cnt_o = word_cnt_q;
`else
    // Word counter not built.
`endif

endmodule

// File: tb/tb_syst_skew.sv
// Directed bench for syst_skew at default parameters (4 lanes x 8 bits).
// Inputs change 1 ns after each rising edge; outputs are checked at that
// same point, i.e. in the cycle that follows the edge.
module tb_syst_skew;

    logic        clk_i;
    logic        rst_i;
    logic [31:0] data_i;
    logic        valid_i;
    logic        last_i;
    logic        ready_o;
    logic [31:0] lane_data_o;
    logic [3:0]  lane_valid_o;
    logic        done_o;
`ifdef SYST_SKEW_WORD_CNT_EN
    logic [15:0] word_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    syst_skew #(
        .LANES (4),
        .LANE_W(8)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .last_i      (last_i),
        .ready_o     (ready_o),
        .lane_data_o (lane_data_o),
        .lane_valid_o(lane_valid_o),
        .done_o      (done_o)
`ifdef SYST_SKEW_WORD_CNT_EN
        ,
        .word_cnt_o  (word_cnt_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] d, input logic [3:0] v,
                           input logic dn, input logic rdy);
        chk({tag, " data"}, lane_data_o, d);
        chk({tag, " valid"}, {28'd0, lane_valid_o}, {28'd0, v});
        chk({tag, " done"}, {31'd0, done_o}, {31'd0, dn});
        chk({tag, " ready"}, {31'd0, ready_o}, {31'd0, rdy});
    endtask

    task automatic drive(input logic v, input logic l, input logic [31:0] d);
        valid_i = v;
        last_i  = l;
        data_i  = d;
    endtask

    initial begin
        rst_i = 1'b0;
        drive(1'b0, 1'b0, 32'h0);
        tick();
        tick();
        chk_out("reset", 32'h0, 4'b0000, 1'b0, 1'b0);
        rst_i = 1'b1;
        tick();
        chk_out("post_reset", 32'h0, 4'b0000, 1'b0, 1'b1);

        // Single-word block, last on the only word.
        drive(1'b1, 1'b1, 32'h04030201);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        chk_out("w1 t1", 32'h00000001, 4'b0001, 1'b0, 1'b0);
        tick();
        chk_out("w1 t2", 32'h00000200, 4'b0010, 1'b0, 1'b0);
        tick();
        chk_out("w1 t3", 32'h00030000, 4'b0100, 1'b0, 1'b0);
        tick();
        chk_out("w1 t4", 32'h04000000, 4'b1000, 1'b1, 1'b0);
        tick();
        chk_out("w1 t5", 32'h0, 4'b0000, 1'b0, 1'b1);

        // Back-to-back block with FF words pushed throughout its drain.
        drive(1'b1, 1'b1, 32'h11223344);
        tick();
        drive(1'b1, 1'b0, 32'hFFFFFFFF);
        chk_out("ff t1", 32'h00000044, 4'b0001, 1'b0, 1'b0);
        tick();
        chk_out("ff t2", 32'h00003300, 4'b0010, 1'b0, 1'b0);
        tick();
        chk_out("ff t3", 32'h00220000, 4'b0100, 1'b0, 1'b0);
        tick();
        chk_out("ff t4", 32'h11000000, 4'b1000, 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        chk_out("ff t5", 32'h0, 4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out("ff flush", 32'h0, 4'b0000, 1'b0, 1'b1);
        end

        // Three-word block, last on the third.
        drive(1'b1, 1'b0, 32'h02020202);
        tick();
        drive(1'b1, 1'b0, 32'h03030303);
        chk_out("b3 t1", 32'h00000002, 4'b0001, 1'b0, 1'b1);
        tick();
        drive(1'b1, 1'b1, 32'h04040404);
        chk_out("b3 t2", 32'h00000203, 4'b0011, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        chk_out("b3 t3", 32'h00020304, 4'b0111, 1'b0, 1'b0);
        tick();
        chk_out("b3 t4", 32'h02030400, 4'b1110, 1'b0, 1'b0);
        tick();
        chk_out("b3 t5", 32'h03040000, 4'b1100, 1'b0, 1'b0);
        tick();
        chk_out("b3 t6", 32'h04000000, 4'b1000, 1'b1, 1'b0);
        tick();
        chk_out("b3 t7", 32'h0, 4'b0000, 1'b0, 1'b1);

        // Word, bubble, last word; last_i set on the bubble must be ignored.
        drive(1'b1, 1'b0, 32'h0A0A0A0A);
        tick();
        drive(1'b0, 1'b1, 32'h55555555);
        chk_out("gap t1", 32'h0000000A, 4'b0001, 1'b0, 1'b1);
        tick();
        drive(1'b1, 1'b1, 32'h0B0B0B0B);
        chk_out("gap t2", 32'h00000A00, 4'b0010, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        chk_out("gap t3", 32'h000A000B, 4'b0101, 1'b0, 1'b0);
        tick();
        chk_out("gap t4", 32'h0A000B00, 4'b1010, 1'b0, 1'b0);
        tick();
        chk_out("gap t5", 32'h000B0000, 4'b0100, 1'b0, 1'b0);
        tick();
        chk_out("gap t6", 32'h0B000000, 4'b1000, 1'b1, 1'b0);
        tick();
        chk_out("gap t7", 32'h0, 4'b0000, 1'b0, 1'b1);

        // Reset in the middle of the drain aborts the block.
        drive(1'b1, 1'b1, 32'h04030201);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        chk_out("rst t1", 32'h00000001, 4'b0001, 1'b0, 1'b0);
        tick();
        chk_out("rst t2", 32'h00000200, 4'b0010, 1'b0, 1'b0);
        rst_i = 1'b0;
        tick();
        chk_out("rst t3", 32'h0, 4'b0000, 1'b0, 1'b0);
        rst_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("rst after", 32'h0, 4'b0000, 1'b0, 1'b1);
        end

`ifdef SYST_SKEW_WORD_CNT_EN
        // Five-word block for the word counter.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, (i == 4), 32'h01010101 * (i + 1));
            tick();
        end
        drive(1'b0, 1'b0, 32'h0);
        chk("cnt drain", {16'd0, word_cnt_o}, 32'd5);
        tick();
        tick();
        tick();
        chk_out("cnt done", 32'h05000000, 4'b1000, 1'b1, 1'b0);
        chk("cnt done", {16'd0, word_cnt_o}, 32'd5);
        tick();
        chk("cnt clear", {16'd0, word_cnt_o}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/syst_skew.md
SYST_SKEW -- requirements
Module: syst_skew

Interface
REQ-001 Parameter LANES, default 4, number of byte lanes / systolic array rows; SHALL be ≥2.
REQ-002 Parameter LANE_W, default 8, bits per lane; data width DW = LANES*LANE_W (32 at defaults).
REQ-003 clk_i  input  1  single clock; all state changes on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-low.
REQ-005 data_i  input  DW  packed lanes from syst_fifo; lane k = data_i[k*LANE_W +: LANE_W].
REQ-006 valid_i  input  1  upstream word valid.
REQ-007 last_i  input  1  qualifies the accepted word as final word of a block.
REQ-008 ready_o  output  1  block can accept a word this cycle.
REQ-009 lane_data_o  output  DW  skewed lanes to array row inputs, same packing as data_i.
REQ-010 lane_valid_o  output  LANES  per-lane valid, bit k for lane k.
REQ-011 done_o  output  1  one-cycle pulse: block fully delivered to array.

Function
REQ-012 Transfer = valid_i & ready_o at rising edge; no other condition accepts a word.
REQ-013 Lane k of a word accepted at edge T SHALL appear on lane_data_o lane k with lane_valid_o[k]=1 during cycle T+k+1 (lane 0 latency 1, lane LANES-1 latency LANES).
REQ-014 Cycles without a transfer SHALL inject zero data with valid 0 into every lane's delay chain (zero fill for array bubbles).
REQ-015 No downstream backpressure; delay chains advance every cycle unconditionally.
REQ-016 FSM states IDLE, STREAM, DRAIN.
REQ-017 IDLE: ready_o=1; transfer with last_i=0 -> STREAM; transfer with last_i=1 -> DRAIN; else stay.
REQ-018 STREAM: ready_o=1; transfer with last_i=1 -> DRAIN; else stay.
REQ-019 DRAIN: ready_o=0; drain counter (width clog2(LANES)+1) loaded with LANES-1 on entry, decrements each cycle; at 0 -> IDLE.
REQ-020 For last word accepted at edge T: DRAIN occupies cycles T+1..T+LANES; done_o=1 only in cycle T+LANES, coincident with lane_valid_o[LANES-1] for that word; IDLE from T+LANES+1.
REQ-021 valid_i/last_i/data_i during DRAIN SHALL be ignored and not alter delay chains.
REQ-022 last_i ignored when valid_i=0.
REQ-023 Back-to-back blocks: a word accepted at T+LANES+1 SHALL be skewed normally with no residue of the previous block.

Reset
REQ-024 rst_i=0 at an edge: state IDLE, all delay-chain registers 0, lane_data_o=0, lane_valid_o=0, done_o=0, drain counter 0, ready_o=0 while rst_i=0.
REQ-025 First cycle after rst_i returns to 1: ready_o=1.
REQ-026 Reset during STREAM/DRAIN aborts the block; no done_o for it; no in-flight lane data emerges after reset.

Configuration
REQ-027 Macro SYST_SKEW_WORD_CNT_EN defined: output word_cnt_o (16 bits) counts transfers in current block, saturates at 16'hFFFF, reset to 0, holds final count during the done_o cycle, cleared to 0 the following cycle.
REQ-028 Macro undefined: word_cnt_o port and its counter absent; all other behaviour identical.

Verification
REQ-029 Reset, then data_i=32'h04030201, last_i=1 accepted at T -> lane0=8'h01 valid at T+1, lane1=8'h02 at T+2, lane2=8'h03 at T+3, lane3=8'h04 at T+4 with done_o=1; ready_o=0 for T+1..T+4; other lanes/cycles valid 0, data 0.
REQ-030 Words 32'h02020202, 32'h03030303, 32'h04040404 back-to-back, last on third at T+2 -> lane3 outputs 02,03,04 in cycles T+4..T+6; done_o only at T+6; ready_o back to 1 at T+7.
REQ-031 Word 32'h0A0A0A0A, one idle cycle, word 32'h0B0B0B0B (last) -> every lane shows 0A, then 00 with valid 0, then 0B, each shifted by its lane latency.
REQ-032 Drive valid_i=1 with 32'hFFFFFFFF throughout DRAIN -> no transfer; no FF bytes ever appear on lane_data_o.
REQ-033 Assert rst_i=0 in cycle T+2 of REQ-029 stimulus -> all outputs 0 next cycle; done_o never pulses; ready_o=1 after release.
REQ-034 With SYST_SKEW_WORD_CNT_EN: 5-word block -> word_cnt_o=5 during done_o cycle, 0 the cycle after.
